// File: rtl/smvm_stream_tx_if.sv
// Host configuration port and val/col/ipv stream bus for smvm_stream_tx.
// master = host/loader side, slave = transmitter side.
interface smvm_stream_tx_if #(
    parameter int AW = 8
);
    logic          cfg_we;
    logic          cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_val;
    logic [7:0]    cfg_col;
    logic          cfg_ipv;
    logic [7:0]    rows;
    logic [7:0]    cols;
    logic [8:0]    nnz;
    logic          start;
    logic [7:0]    val_out;
    logic [7:0]    col_out;
    logic          ipv_out;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_val, cfg_col, cfg_ipv,
        output rows, cols, nnz, start,
        input  val_out, col_out, ipv_out, busy, done, err
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_val, cfg_col, cfg_ipv,
        input  rows, cols, nnz, start,
        output val_out, col_out, ipv_out, busy, done, err
    );
endinterface

// File: rtl/smvm_stream_tx.sv
// SMVM input stream transmitter: replays a buffered vector and CSR entry
// list as header, vector, matrix entries and terminator on the val/col/ipv bus.
module smvm_stream_tx #(
    parameter int MAX_COLS = 128,
    parameter int MAX_NNZ  = 256,
    parameter int AW       = 8
) (
    input logic             clk,
    input logic             rst_n,
    smvm_stream_tx_if.slave bus
);
    localparam int VAW = $clog2(MAX_COLS);
    localparam int MAW = $clog2(MAX_NNZ);

    typedef struct packed {
        logic       ipv;
        logic [7:0] col;
        logic [7:0] val;
    } mat_ent_t;

    typedef enum logic [2:0] {
        IDLE, HDR, VEC, MAT, TERM
    } state_t;

    logic [7:0] vec_mem [MAX_COLS];
    mat_ent_t   mat_mem [MAX_NNZ];
    logic [7:0] vec_q;
    mat_ent_t   mat_q;

    state_t     state;
    logic [7:0] cols_q;
    logic [8:0] nnz_q;
    logic [8:0] cnt;
    logic [8:0] ra;

    logic [7:0] val_q;
    logic [7:0] col_q;
    logic       ipv_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic           idle;
    logic           vec_ok;
    logic           mat_ok;
    logic           wr_vec;
    logic           wr_mat;
    logic           wr_bad;
    logic           cfg_ok;
    logic           go;
    logic           st_bad;
    logic           vec_last;
    logic           mat_last;
    logic [VAW-1:0] vec_ra;
    logic [MAW-1:0] mat_ra;
    logic [VAW-1:0] vec_wa;
    logic [MAW-1:0] mat_wa;

    always_comb begin
        idle     = (state == IDLE);
        vec_wa   = bus.cfg_addr[VAW-1:0];
        mat_wa   = bus.cfg_addr[MAW-1:0];
        vec_ok   = 32'(bus.cfg_addr) < MAX_COLS;
        mat_ok   = (32'(bus.cfg_addr) < MAX_NNZ)
                 && (bus.cfg_val != 8'd0)
                 && (32'(bus.cfg_col) < MAX_COLS);
        wr_vec   = bus.cfg_we && idle && !bus.cfg_sel && vec_ok;
        wr_mat   = bus.cfg_we && idle && bus.cfg_sel && mat_ok;
        wr_bad   = bus.cfg_we && !(wr_vec || wr_mat);
        cfg_ok   = (bus.rows != 8'd0)
                 && (bus.cols != 8'd0)
                 && (32'(bus.cols) <= MAX_COLS)
                 && (bus.nnz != 9'd0)
                 && (32'(bus.nnz) <= MAX_NNZ);
        go       = idle && bus.start && cfg_ok;
        st_bad   = idle && bus.start && !cfg_ok;
        vec_last = (cnt == {1'b0, cols_q});
        mat_last = (cnt == nnz_q);
        vec_ra   = idle ? '0 : ra[VAW-1:0];
        mat_ra   = '0;
        if (state == MAT)
            mat_ra = ra[MAW-1:0];
        else if (state == VEC && vec_last)
            mat_ra = MAW'(1);
    end

    // Prefetch keeps the next element one cycle ahead; a write landing
    // together with start is forwarded so the frame carries it.
    always_ff @(posedge clk) begin
        if (wr_vec)
            vec_mem[vec_wa] <= bus.cfg_val;
        if (wr_mat)
            mat_mem[mat_wa] <= '{ipv: bus.cfg_ipv,
                                 col: bus.cfg_col,
                                 val: bus.cfg_val};
        if (wr_vec && vec_wa == vec_ra)
            vec_q <= bus.cfg_val;
        else
            vec_q <= vec_mem[vec_ra];
        mat_q <= mat_mem[mat_ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cols_q <= '0;
            nnz_q  <= '0;
            cnt    <= '0;
            ra     <= '0;
            val_q  <= '0;
            col_q  <= '0;
            ipv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= wr_bad || st_bad;
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        cols_q <= bus.cols;
                        nnz_q  <= bus.nnz;
                        ra     <= 9'd1;
                        busy_q <= 1'b1;
                        val_q  <= bus.rows;
                        col_q  <= bus.cols;
                        ipv_q  <= 1'b0;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    val_q <= vec_q;
                    col_q <= '0;
                    ipv_q <= 1'b0;
                    cnt   <= 9'd1;
                    ra    <= ra + 9'd1;
                    state <= VEC;
                end
                VEC: begin
                    if (vec_last) begin
                        val_q <= mat_q.val;
                        col_q <= mat_q.col;
                        ipv_q <= mat_q.ipv | (nnz_q == 9'd1);
                        cnt   <= 9'd1;
                        ra    <= 9'd2;
                        state <= MAT;
                    end else begin
                        val_q <= vec_q;
                        cnt   <= cnt + 9'd1;
                        ra    <= ra + 9'd1;
                    end
                end
                MAT: begin
                    if (mat_last) begin
                        val_q  <= '0;
                        col_q  <= '0;
                        ipv_q  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= TERM;
                    end else begin
                        val_q <= mat_q.val;
                        col_q <= mat_q.col;
                        ipv_q <= mat_q.ipv | (cnt + 9'd1 == nnz_q);
                        cnt   <= cnt + 9'd1;
                        ra    <= ra + 9'd1;
                    end
                end
                TERM: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.val_out = val_q;
    assign bus.col_out = col_q;
    assign bus.ipv_out = ipv_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule
